// File: rtl/aes_pkg.sv
// Shared constants and FSM encoding for the AES
// request arbiter and its round-robin picker.
package aes_pkg;

  localparam int AES_BLOCK_W     = 128;
  localparam int AES_KEY_W       = 128;
  localparam int TIMEOUT_CYC_DEF = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } arb_state_e;

endpackage

// File: rtl/aes_rr_pick.sv
// Combinational round-robin picker: first set request
// strictly after last_i, wrapping back to 0..last_i.
module aes_rr_pick #(
  parameter int N   = 2,
  parameter int IDW = 1
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] last_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i > int'(last_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
    // wrap-around pass covers 0..last_i
    for (int i = 0; i < N; i++) begin
      if (!found && req_i[i] && (i <= int'(last_i))) begin
        found    = 1'b1;
        gnt_o[i] = 1'b1;
        idx_o    = IDW'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/aes_req_arbiter.sv
// Shares one AES core between NUM_REQ requesters:
// round-robin grant, timed run, valid/ready response.
module aes_req_arbiter
  import aes_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ID_W        = 1,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                           AES_clk,
  input  logic                           AES_rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*AES_BLOCK_W-1:0] req_data,
  input  logic [NUM_REQ*AES_KEY_W-1:0]   req_key,
  output logic                           resp_valid,
  input  logic                           resp_ready,
  output logic [ID_W-1:0]                resp_id,
  output logic [AES_BLOCK_W-1:0]         resp_data,
  output logic                           resp_err,
  output logic                           core_en,
  output logic [AES_BLOCK_W-1:0]         core_data_in,
  output logic [AES_KEY_W-1:0]           core_key_in,
  input  logic [AES_BLOCK_W-1:0]         core_data_out,
  input  logic                           core_data_out_valid
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e             state_q, state_d;
  logic [ID_W-1:0]        last_q, last_d;
  logic [ID_W-1:0]        id_q, id_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   en_q, en_d;
  logic [AES_BLOCK_W-1:0] din_q, din_d;
  logic [AES_KEY_W-1:0]   key_q, key_d;
  logic [AES_BLOCK_W-1:0] rdata_q, rdata_d;
  logic                   err_q, err_d;

  logic [NUM_REQ-1:0]     gnt_oh;
  logic [ID_W-1:0]        gnt_idx;
  logic                   any_req;
  logic [AES_BLOCK_W-1:0] sel_data;
  logic [AES_KEY_W-1:0]   sel_key;

  aes_rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_W)
  ) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (gnt_oh),
    .idx_o  (gnt_idx),
    .any_o  (any_req)
  );

  always_comb begin
    sel_data = '0;
    sel_key  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_data = sel_data | req_data[i*AES_BLOCK_W +: AES_BLOCK_W];
        sel_key  = sel_key | req_key[i*AES_KEY_W +: AES_KEY_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    en_d    = en_q;
    din_d   = din_q;
    key_d   = key_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          din_d   = sel_data;
          key_d   = sel_key;
          id_d    = gnt_idx;
          last_d  = gnt_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        en_d    = 1'b1;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // a result in the timeout cycle still counts as success
        if (core_data_out_valid) begin
          rdata_d = core_data_out;
          err_d   = 1'b0;
          en_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          en_d    = 1'b0;
          state_d = DONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AES_clk or negedge AES_rst_n) begin
    if (!AES_rst_n) begin
      state_q <= IDLE;
      last_q  <= ID_W'(NUM_REQ - 1);
      id_q    <= '0;
      cnt_q   <= '0;
      en_q    <= 1'b0;
      din_q   <= '0;
      key_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      din_q   <= din_d;
      key_q   <= key_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready    = (state_q == IDLE) ? gnt_oh : '0;
  assign resp_valid   = (state_q == DONE);
  assign resp_id      = id_q;
  assign resp_data    = rdata_q;
  assign resp_err     = err_q;
  assign core_en      = en_q;
  assign core_data_in = din_q;
  assign core_key_in  = key_q;

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Bench for aes_req_arbiter with a stub AES core and
// a response scoreboard.
module tb_aes_req_arbiter;
  import aes_pkg::*;

  localparam int N  = 2;
  localparam int IW = 1;
  localparam int TO = 8;

  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] R1_PT    = 128'h0000007f000000000000000000000000;
  localparam logic [127:0] R1_KEY   = 128'haa2bdb40bff6a5e8caa9ba3ebc1e2acc;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]     req_valid = '0;
  logic [N-1:0]     req_ready;
  logic [N*128-1:0] req_data = '0;
  logic [N*128-1:0] req_key = '0;
  logic             resp_valid;
  logic             resp_ready = 1'b0;
  logic [IW-1:0]    resp_id;
  logic [127:0]     resp_data;
  logic             resp_err;
  logic             core_en;
  logic [127:0]     core_data_in;
  logic [127:0]     core_key_in;
  logic [127:0]     core_data_out;
  logic             core_dov;

  int stub_lat = 4;
  bit stub_off = 1'b0;
  int scnt = 0;
  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  int nresp = 0;

  typedef struct packed {
    logic [IW-1:0] id;
    logic          err;
    logic [127:0]  data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  aes_req_arbiter #(
    .NUM_REQ     (N),
    .ID_W        (IW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .AES_clk             (clk),
    .AES_rst_n           (rst_n),
    .req_valid           (req_valid),
    .req_ready           (req_ready),
    .req_data            (req_data),
    .req_key             (req_key),
    .resp_valid          (resp_valid),
    .resp_ready          (resp_ready),
    .resp_id             (resp_id),
    .resp_data           (resp_data),
    .resp_err            (resp_err),
    .core_en             (core_en),
    .core_data_in        (core_data_in),
    .core_key_in         (core_key_in),
    .core_data_out       (core_data_out),
    .core_data_out_valid (core_dov)
  );

  // stand-in cipher: exact for the FIPS-197 vector, keyed mix otherwise
  function automatic logic [127:0] enc(input logic [127:0] pt,
                                       input logic [127:0] key);
    if (pt == FIPS_PT && key == FIPS_KEY) return FIPS_CT;
    return pt ^ {key[63:0], key[127:64]} ^ 128'hc3c3_5a5a_0f0f_9696_3c3c_a5a5_f0f0_6969;
  endfunction

  assign core_data_out = enc(core_data_in, core_key_in);
  assign core_dov = core_en && !stub_off && (scnt == stub_lat);

  always @(posedge clk) begin
    scnt <= core_en ? scnt + 1 : 0;
    cyc  <= cyc + 1;
  end

  always @(negedge clk) begin
    if (rst_n && resp_valid && resp_ready) begin
      nresp++;
      nvec++;
      if (sb.size() == 0) begin
        nerr++;
        $display("FAIL resp_unexpected: id=%0d data=%h", resp_id, resp_data);
      end else begin
        mon_e = sb.pop_front();
        if ({resp_id, resp_err, resp_data} !== {mon_e.id, mon_e.err, mon_e.data}) begin
          nerr++;
          $display("FAIL resp: got id=%0d err=%0b data=%h want id=%0d err=%0b data=%h",
                   resp_id, resp_err, resp_data, mon_e.id, mon_e.err, mon_e.data);
        end
      end
    end
  end

  task automatic wait_ev(input int w, input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim && !ok; k++) begin
      @(negedge clk);
      case (w)
        0: ok = req_ready[0];
        1: ok = req_ready[1];
        2: ok = |req_ready;
        3: ok = resp_valid;
        default: ok = (sb.size() == 0);
      endcase
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({resp_valid, req_ready, core_en, resp_err, resp_id} !== '0) begin
      nerr++;
      $display("FAIL rst_ctrl: got %b want 0",
               {resp_valid, req_ready, core_en, resp_err, resp_id});
    end
    nvec++;
    if ({core_data_in, core_key_in, resp_data} !== '0) begin
      nerr++;
      $display("FAIL rst_data: got %h/%h/%h want 0", core_data_in, core_key_in, resp_data);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_fips();
    bit ok;
    bit bad;
    int g;
    stub_lat = 4;
    resp_ready = 1'b1;
    req_data[127:0] = FIPS_PT;
    req_key[127:0] = FIPS_KEY;
    sb.push_back('{id: 1'b0, err: 1'b0, data: FIPS_CT});
    @(posedge clk);
    #1 req_valid = 2'b01;
    wait_ev(0, 20, ok);
    g = cyc;
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL fips_grant: got no req_ready[0] want a grant");
    end
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    nvec++;
    if (core_en !== 1'b0) begin
      nerr++;
      $display("FAIL fips_load_en: got %b want 0", core_en);
    end
    @(negedge clk);
    nvec++;
    if ({core_en, core_data_in, core_key_in} !== {1'b1, FIPS_PT, FIPS_KEY}) begin
      nerr++;
      $display("FAIL fips_core_in: got en=%b %h %h want 1 %h %h",
               core_en, core_data_in, core_key_in, FIPS_PT, FIPS_KEY);
    end
    bad = 1'b0;
    for (int k = 0; k < 40 && !resp_valid; k++) begin
      @(negedge clk);
      if (!resp_valid && core_en !== 1'b1) bad = 1'b1;
    end
    nvec++;
    if (bad || !resp_valid) begin
      nerr++;
      $display("FAIL fips_en_hold: got bad=%b valid=%b want 0/1", bad, resp_valid);
    end
    nvec++;
    if ((cyc - g) != 3 + stub_lat || core_en !== 1'b0) begin
      nerr++;
      $display("FAIL fips_latency: got %0d en=%b want %0d en=0", cyc - g, core_en, 3 + stub_lat);
    end
    wait_ev(4, 20, ok);
  endtask

  task automatic run_single(input int id, input logic [127:0] pt, input logic [127:0] key,
                            input exp_t e, output int lat);
    bit ok;
    int g;
    req_data[id*128 +: 128] = pt;
    req_key[id*128 +: 128] = key;
    sb.push_back(e);
    @(posedge clk);
    #1 req_valid[id] = 1'b1;
    wait_ev(id, 20, ok);
    g = cyc;
    @(posedge clk);
    #1 req_valid[id] = 1'b0;
    wait_ev(3, 40, ok);
    lat = ok ? cyc - g : -1;
  endtask

  task automatic test_timeout();
    int lat;
    bit ok;
    stub_off = 1'b1;
    run_single(1, R1_PT, R1_KEY, '{id: 1'b1, err: 1'b1, data: '0}, lat);
    nvec++;
    if (lat != 3 + TO - 1 || {core_en, resp_err, resp_data} !== {1'b0, 1'b1, 128'h0}) begin
      nerr++;
      $display("FAIL timeout: got lat=%0d en=%b err=%b data=%h want lat=%0d en=0 err=1 data=0",
               lat, core_en, resp_err, resp_data, 3 + TO - 1);
    end
    wait_ev(4, 20, ok);
    stub_off = 1'b0;
  endtask

  task automatic test_simul();
    int lat;
    bit ok;
    stub_lat = TO - 1;
    run_single(0, R1_PT, FIPS_KEY, '{id: 1'b0, err: 1'b0, data: enc(R1_PT, FIPS_KEY)}, lat);
    nvec++;
    if (lat != 3 + TO - 1 || resp_err !== 1'b0) begin
      nerr++;
      $display("FAIL simul: got lat=%0d err=%b want lat=%0d err=0", lat, resp_err, 3 + TO - 1);
    end
    wait_ev(4, 20, ok);
  endtask

  task automatic test_backpressure();
    bit ok;
    logic [127:0] c1;
    stub_lat = 3;
    resp_ready = 1'b0;
    req_data = {FIPS_PT, R1_PT};
    req_key = {R1_KEY, R1_KEY};
    c1 = enc(FIPS_PT, R1_KEY);
    sb.push_back('{id: 1'b1, err: 1'b0, data: c1});
    sb.push_back('{id: 1'b0, err: 1'b0, data: enc(R1_PT, R1_KEY)});
    @(posedge clk);
    #1 req_valid = 2'b10;
    wait_ev(1, 20, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL bp_grant1: got no req_ready[1] want a grant");
    end
    @(posedge clk);
    #1 req_valid = 2'b01;
    wait_ev(3, 40, ok);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      nvec++;
      if ({resp_valid, resp_id, core_en, req_ready, resp_err, resp_data} !==
          {1'b1, 1'b1, 1'b0, 2'b00, 1'b0, c1}) begin
        nerr++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%0d en=%b rdy=%b err=%b d=%h want 1 1 0 00 0 %h",
                 k, resp_valid, resp_id, core_en, req_ready, resp_err, resp_data, c1);
      end
    end
    @(posedge clk);
    #1 resp_ready = 1'b1;
    wait_ev(0, 20, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL bp_grant0: got no req_ready[0] after handshake want a grant");
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_ev(4, 40, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL bp_drain: got %0d pending want 0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    int n0;
    stub_lat = 20;
    req_data[127:0] = FIPS_PT;
    req_key[127:0] = FIPS_KEY;
    @(posedge clk);
    #1 req_valid = 2'b01;
    wait_ev(0, 20, ok);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (3) @(negedge clk);
    nvec++;
    if (core_en !== 1'b1) begin
      nerr++;
      $display("FAIL rmid_run: got en=%b want 1", core_en);
    end
    #2 rst_n = 1'b0;
    #1;
    nvec++;
    if ({core_en, resp_valid, req_ready, resp_err, resp_id,
         core_data_in, core_key_in, resp_data} !== '0) begin
      nerr++;
      $display("FAIL rmid_async: got en=%b v=%b din=%h want all 0", core_en, resp_valid, core_data_in);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    n0 = nresp;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    nvec++;
    if (seen || nresp != n0) begin
      nerr++;
      $display("FAIL rmid_noresp: got valid_seen=%b resp=%0d want 0", seen, nresp - n0);
    end
  endtask

  task automatic test_contention();
    bit ok;
    logic [N-1:0] expg;
    stub_lat = 2;
    resp_ready = 1'b1;
    req_data = {R1_PT, FIPS_PT};
    req_key = {R1_KEY, FIPS_KEY};
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) sb.push_back('{id: 1'b0, err: 1'b0, data: FIPS_CT});
      else sb.push_back('{id: 1'b1, err: 1'b0, data: enc(R1_PT, R1_KEY)});
    end
    @(posedge clk);
    #1 req_valid = 2'b11;
    for (int i = 0; i < 4; i++) begin
      expg = (i % 2 == 0) ? 2'b01 : 2'b10;
      wait_ev(2, 40, ok);
      nvec++;
      if (!ok || req_ready !== expg) begin
        nerr++;
        $display("FAIL cont_grant[%0d]: got %b want %b", i, req_ready, expg);
      end
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_ev(4, 60, ok);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL cont_drain: got %0d pending want 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_timeout();
    test_simul();
    test_backpressure();
    test_reset_mid();
    test_contention();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

endmodule
